// File: rtl/vending_pkg.sv
// ============================================================================
//  Module      : vending_pkg
//  Description : Shared types and constants for the multi-product vending
//                controller. Holds the controller state enum, the physical
//                coin denominations and the default price/stock settings.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vending_pkg;

    // Controller state. IDLE and CREDIT differ only by whether credit is zero.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    // Physical coin denominations, largest first for the greedy change path.
    localparam int unsigned c_coin_50 = 50;
    localparam int unsigned c_coin_10 = 10;
    localparam int unsigned c_coin_5  = 5;
    localparam int unsigned c_coin_1  = 1;

    // Default product table: four products, 8-bit prices, product 0 in the
    // least-significant slice.
    localparam logic [31:0] c_default_prices     = {8'd25, 8'd20, 8'd15, 8'd10};
    localparam int          c_default_stock_init = 5;

endpackage : vending_pkg

`default_nettype wire

// File: rtl/vm_coin_change.sv
// ============================================================================
//  Module      : vm_coin_change
//  Description : Combinational greedy change selector. Given the credit still
//                owed, returns the largest coin not exceeding it and the
//                credit that remains once that coin is paid out.
//  Ports       : i_credit     - credit still owed
//                o_coin       - coin to pay this cycle (0 when credit is 0)
//                o_credit_rem - credit after paying o_coin
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vm_coin_change
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8,
    parameter int MONEY_W  = 6
) (
    input  logic [CREDIT_W-1:0] i_credit,
    output logic [MONEY_W-1:0]  o_coin,
    output logic [CREDIT_W-1:0] o_credit_rem
);

    logic [CREDIT_W-1:0] w_coin;

    always_comb begin
        w_coin = '0;
        if (i_credit >= CREDIT_W'(c_coin_50)) begin
            w_coin = CREDIT_W'(c_coin_50);
        end else if (i_credit >= CREDIT_W'(c_coin_10)) begin
            w_coin = CREDIT_W'(c_coin_10);
        end else if (i_credit >= CREDIT_W'(c_coin_5)) begin
            w_coin = CREDIT_W'(c_coin_5);
        end else if (i_credit >= CREDIT_W'(c_coin_1)) begin
            w_coin = CREDIT_W'(c_coin_1);
        end
    end

    assign o_coin       = MONEY_W'(w_coin);
    assign o_credit_rem = i_credit - w_coin;

endmodule : vm_coin_change

`default_nettype wire

// File: rtl/vending_machine_multi.sv
// ============================================================================
//  Module      : vending_machine_multi
//  Description : Multi-product vending controller with per-product prices and
//                stock counters, coin crediting, one-hot selection, and greedy
//                coin-by-coin change return. All outputs are registered.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                money, money_valid  - coin value and its one-cycle strobe
//                drink_choose        - one-hot selection request
//                cancel              - return all credit
//                restock             - reload all stock (IDLE only)
//                drink_out           - one-hot, one-cycle dispense pulse
//                change/change_valid - coin being returned this cycle
//                credit              - current credit
//                busy                - vending or returning change
//                sold_out            - per-product empty flags
//                err                 - one-cycle pulse on a rejected request
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int                               NUM_DRINKS = 4,
    parameter int                               MONEY_W    = 6,
    parameter int                               CREDIT_W   = 8,
    parameter int                               STOCK_W    = 4,
    parameter int                               STOCK_INIT = c_default_stock_init,
    parameter logic [NUM_DRINKS*CREDIT_W-1:0]   PRICES     = c_default_prices
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MONEY_W-1:0]    money,
    input  logic                  money_valid,
    input  logic [NUM_DRINKS-1:0] drink_choose,
    input  logic                  cancel,
    input  logic                  restock,
    output logic [NUM_DRINKS-1:0] drink_out,
    output logic [MONEY_W-1:0]    change,
    output logic                  change_valid,
    output logic [CREDIT_W-1:0]   credit,
    output logic                  busy,
    output logic [NUM_DRINKS-1:0] sold_out,
    output logic                  err
);

    localparam logic [STOCK_W-1:0] c_stock_init = STOCK_W'(STOCK_INIT);

    state_t                               r_state, w_state_nxt;
    logic [CREDIT_W-1:0]                  r_credit, w_credit_nxt;
    logic [NUM_DRINKS-1:0][STOCK_W-1:0]   r_stock, w_stock_nxt;
    logic [NUM_DRINKS-1:0]                r_drink_out, w_drink_out_nxt;
    logic [MONEY_W-1:0]                   r_change, w_change_nxt;
    logic                                 r_change_valid, w_change_valid_nxt;
    logic                                 r_busy, w_busy_nxt;
    logic [NUM_DRINKS-1:0]                r_sold_out, w_sold_out_nxt;
    logic                                 r_err, w_err_nxt;

    // Greedy change path, always fed by the registered credit.
    logic [MONEY_W-1:0]  w_coin;
    logic [CREDIT_W-1:0] w_credit_rem;

    vm_coin_change #(
        .CREDIT_W (CREDIT_W),
        .MONEY_W  (MONEY_W)
    ) u_coin_change (
        .i_credit     (r_credit),
        .o_coin       (w_coin),
        .o_credit_rem (w_credit_rem)
    );

    // Selection decode. Price and stock lookups are only meaningful when the
    // request is one-hot, so OR-ing over the set bits is sufficient.
    logic                w_sel_onehot;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_sel_in_stock;
    logic                w_sel_valid;

    always_comb begin
        w_sel_price    = '0;
        w_sel_in_stock = 1'b0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (drink_choose[i]) begin
                w_sel_price    = w_sel_price | PRICES[i*CREDIT_W +: CREDIT_W];
                w_sel_in_stock = w_sel_in_stock | (r_stock[i] != '0);
            end
        end
    end

    assign w_sel_onehot = (drink_choose != '0) &&
                          ((drink_choose & (drink_choose - 1'b1)) == '0);
    assign w_sel_valid  = w_sel_onehot && (r_credit >= w_sel_price) && w_sel_in_stock;

    // Coin acceptance: known denomination and no accumulator overflow.
    logic              w_coin_known;
    logic [CREDIT_W:0] w_credit_sum;

    assign w_coin_known = (money == MONEY_W'(c_coin_50)) || (money == MONEY_W'(c_coin_10)) ||
                          (money == MONEY_W'(c_coin_5))  || (money == MONEY_W'(c_coin_1));
    assign w_credit_sum = {1'b0, r_credit} + (CREDIT_W + 1)'(money);

    always_comb begin
        w_state_nxt        = r_state;
        w_credit_nxt       = r_credit;
        w_stock_nxt        = r_stock;
        w_drink_out_nxt    = '0;
        w_change_nxt       = '0;
        w_change_valid_nxt = 1'b0;
        w_err_nxt          = 1'b0;

        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                if (cancel) begin
                    // First coin goes out on the same edge that takes cancel.
                    if (r_credit != '0) begin
                        w_change_nxt       = w_coin;
                        w_change_valid_nxt = 1'b1;
                        w_credit_nxt       = w_credit_rem;
                        w_state_nxt        = ST_CHANGE;
                    end
                end else if (drink_choose != '0) begin
                    if (w_sel_valid) begin
                        w_state_nxt     = ST_VEND;
                        w_drink_out_nxt = drink_choose;
                        w_credit_nxt    = r_credit - w_sel_price;
                        for (int i = 0; i < NUM_DRINKS; i++) begin
                            if (drink_choose[i]) begin
                                w_stock_nxt[i] = r_stock[i] - STOCK_W'(1);
                            end
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (money_valid) begin
                    if (w_coin_known && !w_credit_sum[CREDIT_W]) begin
                        w_credit_nxt = w_credit_sum[CREDIT_W-1:0];
                        w_state_nxt  = ST_CREDIT;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end

                // A vend never coincides with a restock because it would have
                // to decrement the very counters being reloaded.
                if (restock && (r_state == ST_IDLE) && (w_state_nxt != ST_VEND)) begin
                    for (int i = 0; i < NUM_DRINKS; i++) begin
                        w_stock_nxt[i] = c_stock_init;
                    end
                end
            end

            // VEND and CHANGE behave the same way: pay one coin while credit
            // remains, otherwise drop back to IDLE.
            ST_VEND, ST_CHANGE: begin
                if (r_credit != '0) begin
                    w_change_nxt       = w_coin;
                    w_change_valid_nxt = 1'b1;
                    w_credit_nxt       = w_credit_rem;
                    w_state_nxt        = ST_CHANGE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == ST_VEND) || (w_state_nxt == ST_CHANGE);

    generate
        for (genvar gi = 0; gi < NUM_DRINKS; gi++) begin : g_sold_out
            assign w_sold_out_nxt[gi] = (w_stock_nxt[gi] == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            for (int i = 0; i < NUM_DRINKS; i++) begin
                r_stock[i] <= c_stock_init;
            end
            r_drink_out    <= '0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_sold_out     <= {NUM_DRINKS{c_stock_init == '0}};
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_credit       <= w_credit_nxt;
            r_stock        <= w_stock_nxt;
            r_drink_out    <= w_drink_out_nxt;
            r_change       <= w_change_nxt;
            r_change_valid <= w_change_valid_nxt;
            r_busy         <= w_busy_nxt;
            r_sold_out     <= w_sold_out_nxt;
            r_err          <= w_err_nxt;
        end
    end

    assign drink_out    = r_drink_out;
    assign change       = r_change;
    assign change_valid = r_change_valid;
    assign credit       = r_credit;
    assign busy         = r_busy;
    assign sold_out     = r_sold_out;
    assign err          = r_err;

endmodule : vending_machine_multi

`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
// ============================================================================
//  Module      : tb_vending_machine_multi
//  Description : Self-checking bench for vending_machine_multi built with
//                STOCK_INIT=2. Directed vector table, a mid-change reset
//                sequence, and random traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vending_machine_multi;

    localparam int c_stock_init = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] money = '0;
    logic       money_valid = 1'b0;
    logic [3:0] drink_choose = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [3:0] drink_out;
    logic [5:0] change;
    logic       change_valid;
    logic [7:0] credit;
    logic       busy;
    logic [3:0] sold_out;
    logic       err;

    vending_machine_multi #(
        .NUM_DRINKS (4),
        .MONEY_W    (6),
        .CREDIT_W   (8),
        .STOCK_W    (4),
        .STOCK_INIT (c_stock_init),
        .PRICES     ({8'd25, 8'd20, 8'd15, 8'd10})
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .money        (money),
        .money_valid  (money_valid),
        .drink_choose (drink_choose),
        .cancel       (cancel),
        .restock      (restock),
        .drink_out    (drink_out),
        .change       (change),
        .change_valid (change_valid),
        .credit       (credit),
        .busy         (busy),
        .sold_out     (sold_out),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mv;
        logic [5:0] money;
        logic [3:0] sel;
        logic       cancel;
        logic       restock;
        logic [3:0] e_drink;
        logic [5:0] e_change;
        logic       e_cv;
        logic [7:0] e_credit;
        logic       e_busy;
        logic [3:0] e_sold;
        logic       e_err;
    } vec_t;

    int errors = 0;
    int checks = 0;

    function automatic vec_t v(input logic mv, input logic [5:0] m, input logic [3:0] s,
                               input logic c, input logic r, input logic [3:0] ed,
                               input logic [5:0] ec, input logic ecv, input logic [7:0] ecr,
                               input logic eb, input logic [3:0] es, input logic ee);
        vec_t t;
        t.mv = mv; t.money = m; t.sel = s; t.cancel = c; t.restock = r;
        t.e_drink = ed; t.e_change = ec; t.e_cv = ecv; t.e_credit = ecr;
        t.e_busy = eb; t.e_sold = es; t.e_err = ee;
        return t;
    endfunction

    task automatic check(input vec_t t, input string name);
        checks++;
        if (drink_out !== t.e_drink || change !== t.e_change || change_valid !== t.e_cv ||
            credit !== t.e_credit || busy !== t.e_busy || sold_out !== t.e_sold || err !== t.e_err) begin
            errors++;
            $display("FAIL %s: got drink=%b change=%0d cv=%b credit=%0d busy=%b sold=%b err=%b ; want drink=%b change=%0d cv=%b credit=%0d busy=%b sold=%b err=%b",
                     name, drink_out, change, change_valid, credit, busy, sold_out, err,
                     t.e_drink, t.e_change, t.e_cv, t.e_credit, t.e_busy, t.e_sold, t.e_err);
        end
    endtask

    task automatic step(input vec_t t, input string name);
        @(negedge clk);
        money_valid  = t.mv;
        money        = t.money;
        drink_choose = t.sel;
        cancel       = t.cancel;
        restock      = t.restock;
        @(posedge clk);
        #1;
        check(t, name);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1; money_valid = 1'b0; money = '0; drink_choose = '0; cancel = 1'b0; restock = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(v(0,0,0,0,0, 0,0,0,0,0,0,0), name);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: credit and stock as integers, pending change as a
    // queue of coins worked out with division; the machine is busy while a
    // vend is pending, coins are queued, or the final coin just went out.
    // ------------------------------------------------------------------
    int m_credit;
    int m_stock[4];
    int m_q[$];
    bit m_vend;
    bit m_tail;
    int price[4] = '{10, 15, 20, 25};

    task automatic model_reset();
        m_credit = 0; m_q.delete(); m_vend = 0; m_tail = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = c_stock_init;
    endtask

    task automatic model_pop(inout vec_t t);
        int coin;
        coin = m_q.pop_front();
        t.e_change = 6'(coin);
        t.e_cv = 1'b1;
        m_credit -= coin;
        if (m_q.size() == 0) m_tail = 1;
    endtask

    task automatic model_start_change(inout vec_t t);
        int dn[4] = '{50, 10, 5, 1};
        int rem;
        rem = m_credit;
        for (int d = 0; d < 4; d++) begin
            repeat (rem / dn[d]) m_q.push_back(dn[d]);
            rem = rem % dn[d];
        end
        model_pop(t);
    endtask

    task automatic model_step(inout vec_t t);
        bit was_idle;
        t.e_drink = '0; t.e_change = '0; t.e_cv = 1'b0; t.e_err = 1'b0;
        if (m_vend || m_q.size() > 0 || m_tail) begin
            if (m_vend) begin
                m_vend = 0;
                if (m_credit > 0) model_start_change(t);
            end else if (m_q.size() > 0) begin
                model_pop(t);
            end else begin
                m_tail = 0;
            end
        end else begin
            was_idle = (m_credit == 0);
            if (t.cancel) begin
                if (m_credit > 0) model_start_change(t);
            end else if (t.sel != 0) begin
                int idx;
                idx = 0;
                for (int i = 0; i < 4; i++) if (t.sel[i]) idx = i;
                if ($countones(t.sel) == 1 && m_credit >= price[idx] && m_stock[idx] > 0) begin
                    t.e_drink = t.sel;
                    m_credit -= price[idx];
                    m_stock[idx]--;
                    m_vend = 1;
                end else begin
                    t.e_err = 1'b1;
                end
            end else if (t.mv) begin
                int m;
                m = int'(t.money);
                if ((m == 1 || m == 5 || m == 10 || m == 50) && (m_credit + m <= 255))
                    m_credit += m;
                else
                    t.e_err = 1'b1;
            end
            if (t.restock && was_idle)
                for (int i = 0; i < 4; i++) m_stock[i] = c_stock_init;
        end
        t.e_credit = 8'(m_credit);
        t.e_busy = m_vend || (m_q.size() > 0) || m_tail;
        for (int i = 0; i < 4; i++) t.e_sold[i] = (m_stock[i] == 0);
    endtask

    vec_t vecs[$];

    initial begin
        // mv money sel cancel restock | drink change cv credit busy sold err
        vecs.push_back(v(1, 5,4'b0000,0,0, 4'b0000, 0,0,  5,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 15,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0010,0,0, 4'b0010, 0,0,  0,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(1,50,4'b0000,0,0, 4'b0000, 0,0, 50,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b1000,0,0, 4'b1000, 0,0, 25,1,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000,10,1, 15,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0001,0,0, 4'b0000,10,1,  5,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 5,1,  0,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 10,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 20,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 30,0,4'b0000,0));
        vecs.push_back(v(1, 5,4'b0000,0,0, 4'b0000, 0,0, 35,0,4'b0000,0));
        vecs.push_back(v(1, 1,4'b0000,0,0, 4'b0000, 0,0, 36,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,1,0, 4'b0000,10,1, 26,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000,10,1, 16,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000,10,1,  6,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 5,1,  1,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 1,1,  0,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 10,0,4'b0000,0));
        vecs.push_back(v(1, 5,4'b0000,0,0, 4'b0000, 0,0, 15,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0001,1,0, 4'b0000,10,1,  5,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 5,1,  0,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 10,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0100,0,0, 4'b0000, 0,0, 10,0,4'b0000,1));
        vecs.push_back(v(1, 7,4'b0000,0,0, 4'b0000, 0,0, 10,0,4'b0000,1));
        vecs.push_back(v(0, 0,4'b0011,0,0, 4'b0000, 0,0, 10,0,4'b0000,1));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0, 10,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0001,0,0, 4'b0001, 0,0,  0,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 10,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0001,0,0, 4'b0001, 0,0,  0,1,4'b0001,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0001,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 10,0,4'b0001,0));
        vecs.push_back(v(0, 0,4'b0001,0,0, 4'b0000, 0,0, 10,0,4'b0001,1));
        vecs.push_back(v(0, 0,4'b0000,1,0, 4'b0000,10,1,  0,1,4'b0001,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0001,0));
        vecs.push_back(v(0, 0,4'b0000,0,1, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0, 10,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0001,0,0, 4'b0001, 0,0,  0,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(1,50,4'b0000,0,0, 4'b0000, 0,0, 50,0,4'b0000,0));
        vecs.push_back(v(1,50,4'b0000,0,0, 4'b0000, 0,0,100,0,4'b0000,0));
        vecs.push_back(v(1,50,4'b0000,0,0, 4'b0000, 0,0,150,0,4'b0000,0));
        vecs.push_back(v(1,50,4'b0000,0,0, 4'b0000, 0,0,200,0,4'b0000,0));
        vecs.push_back(v(1,50,4'b0000,0,0, 4'b0000, 0,0,250,0,4'b0000,0));
        vecs.push_back(v(1,10,4'b0000,0,0, 4'b0000, 0,0,250,0,4'b0000,1));
        vecs.push_back(v(1, 5,4'b0000,0,0, 4'b0000, 0,0,255,0,4'b0000,0));
        vecs.push_back(v(1, 1,4'b0000,0,0, 4'b0000, 0,0,255,0,4'b0000,1));
        vecs.push_back(v(0, 0,4'b0000,1,0, 4'b0000,50,1,205,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000,50,1,155,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000,50,1,105,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000,50,1, 55,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000,50,1,  5,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 5,1,  0,1,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(0, 0,4'b0000,1,0, 4'b0000, 0,0,  0,0,4'b0000,0));
        vecs.push_back(v(0,10,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0));

        do_reset("reset");
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of returning change aborts it.
        step(v(1,50,4'b0000,0,0, 4'b0000, 0,0, 50,0,4'b0000,0), "mid_rst_coin1");
        step(v(1,50,4'b0000,0,0, 4'b0000, 0,0,100,0,4'b0000,0), "mid_rst_coin2");
        step(v(0, 0,4'b1000,0,0, 4'b1000, 0,0, 75,1,4'b0000,0), "mid_rst_sel");
        step(v(0, 0,4'b0000,0,0, 4'b0000,50,1, 25,1,4'b0000,0), "mid_rst_coin_out");
        do_reset("mid_rst_abort");
        step(v(1, 5,4'b0000,0,0, 4'b0000, 0,0,  5,0,4'b0000,0), "post_rst_coin");
        step(v(0, 0,4'b0000,1,0, 4'b0000, 5,1,  0,1,4'b0000,0), "post_rst_cancel");
        step(v(0, 0,4'b0000,0,0, 4'b0000, 0,0,  0,0,4'b0000,0), "post_rst_idle");

        // Random traffic against the model.
        do_reset("rand_reset");
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            vec_t t;
            logic [3:0] one;
            one = 4'b0001;
            t.mv = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 3))
                    0: t.money = 6'd1;
                    1: t.money = 6'd5;
                    2: t.money = 6'd10;
                    default: t.money = 6'd50;
                endcase
            end else begin
                t.money = 6'($urandom_range(0, 63));
            end
            t.sel = '0;
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) t.sel = one << $urandom_range(0, 3);
                else t.sel = 4'($urandom_range(1, 15));
            end
            t.cancel  = ($urandom_range(0, 19) == 0);
            t.restock = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset($sformatf("rand_reset%0d", n));
                model_reset();
            end else begin
                model_step(t);
                step(t, $sformatf("rand%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vending_machine_multi

`default_nettype wire
